// File: rtl/logs_orbit_collector.sv
// Orbit collector for logs_iterate_map: resets the map, drops transient iterates,
// captures SAMPLES iterates per r value, hands each column off via valid/ack, then steps r.
module logs_orbit_collector #(
  parameter int unsigned     FRAC    = 4,
  parameter int unsigned     SETTLE  = 16,
  parameter int unsigned     SAMPLES = 8,
  parameter logic [FRAC+1:0] R_START = 6'h20,
  parameter logic [FRAC+1:0] R_STEP  = 6'h01,
  parameter logic [FRAC+1:0] R_END   = 6'h3F,
  parameter int unsigned     COL_W   = 6,
  localparam int unsigned    AW      = (SAMPLES > 1) ? $clog2(SAMPLES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [FRAC-1:0]   x,
  input  logic              next_ready,
  output logic [FRAC+1:0]   r,
  output logic              map_reset,
  output logic              col_valid,
  input  logic              col_ack,
  output logic [COL_W-1:0]  col_index,
  input  logic [AW-1:0]     rd_addr,
  output logic [FRAC-1:0]   rd_data,
  output logic              sweep_wrap
);

  localparam int unsigned RW  = FRAC + 2;
  localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    SETTLE_S = 3'd2,
    CAPTURE = 3'd3,
    PRESENT = 3'd4
  } state_t;

  state_t state, state_next;

  logic [SCW-1:0]  settle_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [FRAC-1:0] samples_q [SAMPLES];

  logic            settle_en;
  logic            wr_en;
  logic            advance;
  logic            settle_last;
  logic            wr_last;
  logic [RW:0]     sum;
  logic            wrap;

  assign settle_last = (settle_cnt == SCW'(SETTLE - 1));
  assign wr_last     = (wr_ptr == AW'(SAMPLES - 1));

  // r step in one extra bit so a carry out of the r field also forces a wrap
  assign sum  = {1'b0, r} + (RW+1)'(R_STEP);
  assign wrap = sum[RW] || (sum > {1'b0, R_END});

  // Live buffer readback; out-of-range addresses read as zero
  assign rd_data = (32'(rd_addr) < SAMPLES) ? samples_q[rd_addr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= START;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    settle_en  = 1'b0;
    wr_en      = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = START;
      end
      START: begin
        state_next = SETTLE_S;
      end
      SETTLE_S: begin
        settle_en = next_ready;
        if (next_ready && settle_last) state_next = CAPTURE;
      end
      CAPTURE: begin
        wr_en = next_ready;
        if (next_ready && wr_last) state_next = PRESENT;
      end
      PRESENT: begin
        // ack takes priority over any coincident next_ready, which is simply ignored here
        advance = col_ack;
        if (col_ack) state_next = run ? START : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r          <= R_START;
      map_reset  <= 1'b1;
      col_valid  <= 1'b0;
      col_index  <= '0;
      sweep_wrap <= 1'b0;
      settle_cnt <= '0;
      wr_ptr     <= '0;
      for (int i = 0; i < int'(SAMPLES); i++) begin
        samples_q[i] <= '0;
      end
    end else begin
      map_reset  <= (state_next == IDLE) || (state_next == START);
      col_valid  <= (state_next == PRESENT);
      sweep_wrap <= 1'b0;

      if (state == START) begin
        settle_cnt <= '0;
        wr_ptr     <= '0;
      end

      if (settle_en) begin
        settle_cnt <= settle_last ? '0 : settle_cnt + SCW'(1);
      end

      if (wr_en) begin
        samples_q[wr_ptr] <= x;
        wr_ptr            <= wr_last ? '0 : wr_ptr + AW'(1);
      end

      // r only moves on the PRESENT exit, so it is stable whenever the map runs
      if (advance) begin
        if (wrap) begin
          r          <= R_START;
          col_index  <= '0;
          sweep_wrap <= 1'b1;
        end else begin
          r          <= sum[RW-1:0];
          col_index  <= col_index + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_logs_orbit_collector.sv
// Self-checking bench for logs_orbit_collector: stub map strobes, column scoreboard,
// table of 32 sweep columns, plus hand-written handshake, run=0, reset and carry-wrap cases.
module tb_logs_orbit_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [3:0] x;
  logic       next_ready;
  logic [5:0] r;
  logic       map_reset;
  logic       col_valid;
  logic       col_ack;
  logic [5:0] col_index;
  logic [2:0] rd_addr;
  logic [3:0] rd_data;
  logic       sweep_wrap;

  logic       run2;
  logic [3:0] x2;
  logic       nr2;
  logic [5:0] r2;
  logic       mr2;
  logic       cv2;
  logic       ack2;
  logic [5:0] ci2;
  logic [0:0] ra2;
  logic [3:0] rd2;
  logic       sw2;

  always #10 clk = ~clk;

  logs_orbit_collector dut (
    .clk(clk), .reset(reset), .run(run), .x(x), .next_ready(next_ready),
    .r(r), .map_reset(map_reset), .col_valid(col_valid), .col_ack(col_ack),
    .col_index(col_index), .rd_addr(rd_addr), .rd_data(rd_data), .sweep_wrap(sweep_wrap)
  );

  logs_orbit_collector #(.SETTLE(1), .SAMPLES(2), .R_STEP(6'h30)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .x(x2), .next_ready(nr2),
    .r(r2), .map_reset(mr2), .col_valid(cv2), .col_ack(ack2),
    .col_index(ci2), .rd_addr(ra2), .rd_data(rd2), .sweep_wrap(sw2)
  );

  typedef struct {
    logic [3:0] base;
    logic [5:0] r_exp;
    logic [5:0] idx_exp;
    logic [5:0] r_after;
    logic [5:0] idx_after;
    logic       wrap_exp;
  } col_vec_t;

  col_vec_t   tbl [32];
  logic [3:0] sb [$];
  logic [3:0] snap [8];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    x = v;
    next_ready = 1'b1;
    tick();
    next_ready = 1'b0;
    tick();
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) pulse(4'hF);
  endtask

  task automatic capture(input logic [3:0] base);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] v;
      v = base + 4'(i);
      sb.push_back(v);
      pulse(v);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!col_valid && n < 50) begin
      tick();
      n++;
    end
    check({name, "_col_valid"}, 32'(col_valid), 32'd1);
  endtask

  // Pop expected samples from the scoreboard and compare against the readback port
  task automatic check_column(input string name);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      snap[a] = rd_data;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_empty: got rd_data %0h expected none", name, rd_data);
      end else begin
        check($sformatf("%s_rd%0d", name, a), 32'(rd_data), 32'(sb.pop_front()));
      end
    end
  endtask

  task automatic check_snap(input string name);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      check($sformatf("%s_rd%0d", name, a), 32'(rd_data), 32'(snap[a]));
    end
  endtask

  task automatic ack_and_check(input string name, input col_vec_t v);
    col_ack = 1'b1;
    tick();
    col_ack = 1'b0;
    check({name, "_cv_clr"}, 32'(col_valid), 32'd0);
    check({name, "_r_next"}, 32'(r), 32'(v.r_after));
    check({name, "_idx_next"}, 32'(col_index), 32'(v.idx_after));
    check({name, "_wrap"}, 32'(sweep_wrap), 32'(v.wrap_exp));
    check({name, "_mr_on"}, 32'(map_reset), 32'd1);
    tick();
    check({name, "_mr_off"}, 32'(map_reset), 32'd0);
    check({name, "_wrap_off"}, 32'(sweep_wrap), 32'd0);
  endtask

  task automatic run_col(input string name, input col_vec_t v);
    check({name, "_r"}, 32'(r), 32'(v.r_exp));
    check({name, "_idx"}, 32'(col_index), 32'(v.idx_exp));
    settle(16);
    capture(v.base);
    wait_valid(name);
    check_column(name);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl[i].base      = 4'(i * 3);
      tbl[i].r_exp     = 6'(32 + i);
      tbl[i].idx_exp   = 6'(i);
      tbl[i].wrap_exp  = (i == 31);
      tbl[i].r_after   = (i == 31) ? 6'h20 : 6'(33 + i);
      tbl[i].idx_after = (i == 31) ? 6'h00 : 6'(i + 1);
    end

    reset = 1'b1; run = 1'b1; x = '0; next_ready = 1'b0; col_ack = 1'b0; rd_addr = '0;
    run2 = 1'b1; x2 = '0; nr2 = 1'b0; ack2 = 1'b0; ra2 = '0;
    tick(); tick(); tick();
    check("rst_r", 32'(r), 32'h20);
    check("rst_mr", 32'(map_reset), 32'd1);
    check("rst_cv", 32'(col_valid), 32'd0);
    check("rst_idx", 32'(col_index), 32'd0);
    check("rst_wrap", 32'(sweep_wrap), 32'd0);
    reset = 1'b0;
    tick();
    check("start_mr_pulse", 32'(map_reset), 32'd0);

    // Column 0 with a long ack stall and stray strobes
    run_col("c0", tbl[0]);
    for (int k = 0; k < 100; k++) begin
      x = 4'hA;
      next_ready = (k % 7 == 0);
      tick();
    end
    next_ready = 1'b0;
    check("hold_cv", 32'(col_valid), 32'd1);
    check_snap("hold");
    ack_and_check("c0", tbl[0]);

    for (int i = 1; i < 32; i++) begin
      run_col($sformatf("c%0d", i), tbl[i]);
      ack_and_check($sformatf("c%0d", i), tbl[i]);
    end

    // run dropped mid-SETTLE: column still completes, then park in IDLE
    check("c32_r", 32'(r), 32'h20);
    settle(5);
    run = 1'b0;
    settle(11);
    capture(4'h4);
    wait_valid("c32");
    check_column("c32");
    col_ack = 1'b1;
    tick();
    col_ack = 1'b0;
    check("idle_r", 32'(r), 32'h21);
    check("idle_idx", 32'(col_index), 32'd1);
    for (int k = 0; k < 10; k++) begin
      x = 4'h5;
      next_ready = 1'b1;
      tick();
    end
    next_ready = 1'b0;
    check("idle_mr", 32'(map_reset), 32'd1);
    check("idle_cv", 32'(col_valid), 32'd0);
    check_snap("idle");
    run = 1'b1;
    tick();
    check("resume_mr_start", 32'(map_reset), 32'd1);
    tick();
    check("resume_mr_settle", 32'(map_reset), 32'd0);

    // Column 33: ack and next_ready together, the sample is dropped
    check("c33_r", 32'(r), 32'h21);
    settle(16);
    capture(4'h9);
    wait_valid("c33");
    check_column("c33");
    x = 4'hC;
    next_ready = 1'b1;
    col_ack = 1'b1;
    tick();
    next_ready = 1'b0;
    col_ack = 1'b0;
    check("ackwin_r", 32'(r), 32'h22);
    check("ackwin_idx", 32'(col_index), 32'd2);
    check_snap("ackwin");
    tick();

    // Asynchronous reset in the middle of CAPTURE
    settle(16);
    for (int i = 0; i < 3; i++) pulse(4'h7);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_r", 32'(r), 32'h20);
    check("arst_mr", 32'(map_reset), 32'd1);
    check("arst_cv", 32'(col_valid), 32'd0);
    check("arst_idx", 32'(col_index), 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      check($sformatf("arst_rd%0d", a), 32'(rd_data), 32'd0);
    end
    tick();
    reset = 1'b0;
    tick();

    // Carry wrap with R_STEP = 6'h30 on the small instance
    for (int i = 0; i < 3; i++) begin
      x2 = 4'(3 + 4 * i);
      nr2 = 1'b1;
      tick();
      nr2 = 1'b0;
      tick();
    end
    check("w2_cv", 32'(cv2), 32'd1);
    check("w2_r", 32'(r2), 32'h20);
    ra2 = 1'b0;
    #1;
    check("w2_rd0", 32'(rd2), 32'h7);
    ra2 = 1'b1;
    #1;
    check("w2_rd1", 32'(rd2), 32'hB);
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    check("w2_r_wrap", 32'(r2), 32'h20);
    check("w2_idx", 32'(ci2), 32'd0);
    check("w2_sw", 32'(sw2), 32'd1);
    check("w2_cv_clr", 32'(cv2), 32'd0);
    tick();
    check("w2_sw_off", 32'(sw2), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
